// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data channels
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // instruction-fetch channel (read-only)
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  input  logic                i_rready,
  // data channel (loads and stores)
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_req_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  input  logic                d_rready,
  // shared memory port
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_req_ready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,
  output logic                m_rready,
  // performance counters
  output logic [31:0]         cnt_i_grant,
  output logic [31:0]         cnt_d_grant,
  output logic [31:0]         cnt_conflict
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    CH_INST = 1'b0,
    CH_DATA = 1'b1
  } chan_t;

  state_t state;
  state_t state_next;
  chan_t  owner;
  chan_t  last_grant;

  // Transaction captured at grant time; held stable for the whole REQ phase.
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [STRB_W-1:0] lat_wstrb;
  logic              lat_write;

  logic i_pend;
  logic d_pend;
  logic grant_inst;
  logic grant_data;

  assign i_pend = i_req_valid;
  assign d_pend = d_read | d_write;

  // Next-state, grant decision and all channel/memory outputs.
  always_comb begin
    state_next  = state;
    grant_inst  = 1'b0;
    grant_data  = 1'b0;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    i_rvalid    = 1'b0;
    i_rdata     = '0;
    d_rvalid    = 1'b0;
    d_rdata     = '0;
    m_addr      = '0;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_rready    = 1'b0;

    case (state)
      IDLE: begin
        if (!rst) begin
          // On contention the channel that did not win last time gets the port.
          if (i_pend && (!d_pend || (last_grant == CH_DATA))) begin
            grant_inst = 1'b1;
          end else if (d_pend) begin
            grant_data = 1'b1;
          end
        end
        i_req_ready = grant_inst;
        d_req_ready = grant_data;
        if (grant_inst || grant_data) begin
          state_next = REQ;
        end
      end

      REQ: begin
        m_addr  = lat_addr;
        m_read  = ~lat_write;
        m_write = lat_write;
        m_wdata = lat_wdata;
        m_wstrb = lat_wstrb;
        if (m_req_ready) begin
          // Stores complete on acceptance; only reads wait for data.
          state_next = lat_write ? IDLE : RESP;
        end
      end

      RESP: begin
        if (owner == CH_INST) begin
          i_rvalid = m_rvalid;
          i_rdata  = m_rdata;
          m_rready = i_rready;
        end else begin
          d_rvalid = m_rvalid;
          d_rdata  = m_rdata;
          m_rready = d_rready;
        end
        if (m_rvalid && m_rready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus owner/pointer and the latched transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= CH_INST;
      last_grant <= CH_DATA;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wstrb  <= '0;
      lat_write  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_inst) begin
        owner      <= CH_INST;
        last_grant <= CH_INST;
        lat_addr   <= i_addr;
        lat_wdata  <= '0;
        lat_wstrb  <= '0;
        lat_write  <= 1'b0;
      end else if (grant_data) begin
        owner      <= CH_DATA;
        last_grant <= CH_DATA;
        lat_addr   <= d_addr;
        lat_wdata  <= d_wdata;
        // A simultaneous read+write is treated as a write; pure reads carry no strobes.
        lat_wstrb  <= d_write ? d_wstrb : '0;
        lat_write  <= d_write;
      end
    end
  end

  // Performance counters; they wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_i_grant  <= '0;
      cnt_d_grant  <= '0;
      cnt_conflict <= '0;
    end else begin
      if (grant_inst) begin
        cnt_i_grant <= cnt_i_grant + 32'd1;
      end
      if (grant_data) begin
        cnt_d_grant <= cnt_d_grant + 32'd1;
      end
      if ((state == IDLE) && i_pend && d_pend) begin
        cnt_conflict <= cnt_conflict + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] i_addr;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_rready;
  logic [31:0] d_addr;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_req_ready;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_rready;
  logic [31:0] m_addr;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_req_ready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] cnt_i_grant;
  logic [31:0] cnt_d_grant;
  logic [31:0] cnt_conflict;

  int checks;
  int errors;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_req_ready(d_req_ready), .d_rdata(d_rdata),
    .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_req_ready(m_req_ready), .m_rdata(m_rdata),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .cnt_i_grant(cnt_i_grant), .cnt_d_grant(cnt_d_grant), .cnt_conflict(cnt_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  ds;
    logic        mrr;
    logic        mrv;
    logic [31:0] mrd;
    logic        irr;
    logic        drr;
    logic [6:0]  hs;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [3:0]  mws;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // {i_req_ready, d_req_ready, m_read, m_write, i_rvalid, d_rvalid, m_rready}
  function automatic logic [6:0] hs_now();
    return {i_req_ready, d_req_ready, m_read, m_write, i_rvalid, d_rvalid, m_rready};
  endfunction

  task automatic add(input logic iv, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] ds,
                     input logic mrr, input logic mrv, input logic [31:0] mrd,
                     input logic irr, input logic drr, input logic [6:0] hs,
                     input logic [31:0] maddr, input logic [31:0] mwd, input logic [3:0] mws,
                     input logic [31:0] ird, input logic [31:0] drd);
    vec_t v;
    v.iv = iv; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.ds = ds;
    v.mrr = mrr; v.mrv = mrv; v.mrd = mrd; v.irr = irr; v.drr = drr;
    v.hs = hs; v.maddr = maddr; v.mwd = mwd; v.mws = mws; v.ird = ird; v.drd = drd;
    tv.push_back(v);
  endtask

  task automatic zero_inputs();
    i_addr = '0; i_req_valid = 1'b0; i_rready = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0; d_wstrb = '0; d_rready = 1'b0;
    m_req_ready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    zero_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reference model: one outstanding transaction record plus round-robin pointer.
  bit          mb_busy;
  bit          mb_accepted;
  bit          mb_inst;
  bit          mb_write;
  logic [31:0] mb_addr;
  logic [31:0] mb_wdata;
  logic [3:0]  mb_wstrb;
  bit          mb_last_inst;
  int unsigned mc_i;
  int unsigned mc_d;
  int unsigned mc_c;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    zero_inputs();

    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("reset_hs", 32'(hs_now()), 32'd0);
    chk("reset_m_addr", m_addr, 32'd0);
    chk("reset_cnts", cnt_i_grant | cnt_d_grant | cnt_conflict, 32'd0);

    // ---------------- table-driven sequence ----------------
    // lone fetch
    add(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
        7'b1000000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
        7'b0010000, 32'h100, 32'h0, 4'h0, 32'h0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0,
        7'b0000101, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF, 32'h0);
    // store with memory stalled for 3 cycles
    add(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h12345678, 4'b0011, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
        7'b0100000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    for (int r = 0; r < 3; r++)
      add(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
          7'b0001000, 32'h200, 32'h12345678, 4'b0011, 32'h0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
        7'b0001000, 32'h200, 32'h12345678, 4'b0011, 32'h0, 32'h0);
    // back in IDLE: a stray m_rvalid is not forwarded
    add(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h99, 1'b1, 1'b1,
        7'b0000000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    // read+write together behaves as a write
    add(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
        7'b0100000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
        7'b0001000, 32'h300, 32'hCAFEF00D, 4'hF, 32'h0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b1,
        7'b0000000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    // data load: strobes forced to zero
    add(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h77, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
        7'b0100000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
        7'b0010000, 32'h400, 32'h77, 4'h0, 32'h0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b1,
        7'b0000011, 32'h0, 32'h0, 4'h0, 32'h0, 32'h55);

    for (int k = 0; k < tv.size(); k++) begin
      i_req_valid = tv[k].iv; i_addr = tv[k].ia; d_read = tv[k].dr; d_write = tv[k].dw;
      d_addr = tv[k].da; d_wdata = tv[k].dwd; d_wstrb = tv[k].ds;
      m_req_ready = tv[k].mrr; m_rvalid = tv[k].mrv; m_rdata = tv[k].mrd;
      i_rready = tv[k].irr; d_rready = tv[k].drr;
      #1;
      chk($sformatf("row%0d_hs", k), 32'(hs_now()), 32'(tv[k].hs));
      chk($sformatf("row%0d_m_addr", k), m_addr, tv[k].maddr);
      chk($sformatf("row%0d_m_wdata", k), m_wdata, tv[k].mwd);
      chk($sformatf("row%0d_m_wstrb", k), 32'(m_wstrb), 32'(tv[k].mws));
      chk($sformatf("row%0d_i_rdata", k), i_rdata, tv[k].ird);
      chk($sformatf("row%0d_d_rdata", k), d_rdata, tv[k].drd);
      tick();
    end
    zero_inputs();
    #1;
    chk("table_cnt_i", cnt_i_grant, 32'd1);
    chk("table_cnt_d", cnt_d_grant, 32'd3);
    chk("table_cnt_conflict", cnt_conflict, 32'd0);

    // ---------------- contention right after reset ----------------
    do_reset();
    i_req_valid = 1'b1; i_addr = 32'h600;
    d_read = 1'b1; d_addr = 32'h700;
    m_req_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0BAD; i_rready = 1'b1; d_rready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (c % 3 == 0)
        chk($sformatf("contention_grant%0d", c / 3), 32'({i_req_ready, d_req_ready}),
            (c == 3) ? 32'd1 : 32'd2);
      else
        chk($sformatf("contention_busy%0d", c), 32'({i_req_ready, d_req_ready}), 32'd0);
      tick();
    end
    zero_inputs();
    #1;
    chk("contention_cnt_conflict", cnt_conflict, 32'd3);
    chk("contention_cnt_i", cnt_i_grant, 32'd2);
    chk("contention_cnt_d", cnt_d_grant, 32'd1);

    // ---------------- response backpressure ----------------
    do_reset();
    d_read = 1'b1; d_addr = 32'h500;
    #1; chk("bp_grant", 32'(d_req_ready), 32'd1);
    tick();
    d_read = 1'b0; m_req_ready = 1'b1;
    #1; chk("bp_req", 32'({m_read, m_write}), 32'd2);
    tick();
    m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hA5A5; d_rready = 1'b0;
    i_rready = 1'b1; i_req_valid = 1'b1; i_addr = 32'h504;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("bp_stall%0d", c), 32'({i_req_ready, m_rready, d_rvalid, i_rvalid}), 32'b0010);
      tick();
    end
    d_rready = 1'b1;
    #1;
    chk("bp_release", 32'({i_req_ready, m_rready, d_rvalid, i_rvalid}), 32'b0110);
    chk("bp_rdata", d_rdata, 32'hA5A5);
    tick();
    m_rvalid = 1'b0;
    #1; chk("bp_idle_again", 32'(i_req_ready), 32'd1);
    tick();
    zero_inputs();

    // ---------------- reset in RESP ----------------
    do_reset();
    i_req_valid = 1'b1; i_addr = 32'h800;
    tick();
    i_req_valid = 1'b0; m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0; m_rvalid = 1'b0;
    #1; chk("rr_in_resp_cnt", cnt_i_grant, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    zero_inputs();
    m_rvalid = 1'b1; i_rready = 1'b1; d_rready = 1'b1;
    #1;
    chk("rr_hs", 32'(hs_now()), 32'd0);
    chk("rr_rdata", i_rdata | d_rdata | m_addr | m_wdata, 32'd0);
    chk("rr_cnts", cnt_i_grant | cnt_d_grant | cnt_conflict, 32'd0);
    m_rvalid = 1'b0;
    i_req_valid = 1'b1; i_addr = 32'h900;
    #1; chk("rr_regrant", 32'(i_req_ready), 32'd1);
    tick();
    i_req_valid = 1'b0; m_req_ready = 1'b1;
    #1;
    chk("rr_req", 32'({m_read, m_write}), 32'd2);
    chk("rr_addr", m_addr, 32'h900);
    tick();
    m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234;
    #1;
    chk("rr_resp", 32'({i_rvalid, d_rvalid, m_rready}), 32'b101);
    chk("rr_resp_data", i_rdata, 32'h1234);
    tick();
    zero_inputs();
    #1; chk("rr_cnt_after", cnt_i_grant, 32'd1);

    // ---------------- randomized run against the transaction model ----------------
    do_reset();
    mb_busy = 0; mb_accepted = 0; mb_inst = 0; mb_write = 0;
    mb_addr = '0; mb_wdata = '0; mb_wstrb = '0; mb_last_inst = 0;
    mc_i = 0; mc_d = 0; mc_c = 0;
    for (int n = 0; n < 3000; n++) begin
      logic ip, dp, win_inst, rr;
      logic [6:0] e_hs;
      logic [31:0] e_maddr, e_mwd, e_ird, e_drd;
      logic [3:0] e_mws;
      i_req_valid = 1'($urandom_range(0, 1));
      i_addr      = $urandom;
      d_read      = ($urandom_range(0, 2) == 0);
      d_write     = ($urandom_range(0, 2) == 0);
      d_addr      = $urandom;
      d_wdata     = $urandom;
      d_wstrb     = 4'($urandom_range(0, 15));
      m_req_ready = 1'($urandom_range(0, 1));
      m_rvalid    = 1'($urandom_range(0, 1));
      m_rdata     = $urandom;
      i_rready    = ($urandom_range(0, 9) < 7);
      d_rready    = ($urandom_range(0, 9) < 7);

      ip = i_req_valid;
      dp = d_read | d_write;
      win_inst = (ip && dp) ? !mb_last_inst : ip;
      rr = mb_inst ? i_rready : d_rready;
      e_hs = '0; e_maddr = '0; e_mwd = '0; e_mws = '0; e_ird = '0; e_drd = '0;
      if (!mb_busy) begin
        if (ip || dp) e_hs = win_inst ? 7'b1000000 : 7'b0100000;
      end else if (!mb_accepted) begin
        e_hs = mb_write ? 7'b0001000 : 7'b0010000;
        e_maddr = mb_addr; e_mwd = mb_wdata; e_mws = mb_wstrb;
      end else begin
        if (mb_inst) begin
          e_hs = {4'b0000, m_rvalid, 1'b0, rr};
          e_ird = m_rdata;
        end else begin
          e_hs = {4'b0000, 1'b0, m_rvalid, rr};
          e_drd = m_rdata;
        end
      end

      #1;
      chk($sformatf("rnd%0d_hs", n), 32'(hs_now()), 32'(e_hs));
      chk($sformatf("rnd%0d_m_addr", n), m_addr, e_maddr);
      chk($sformatf("rnd%0d_m_wdata", n), m_wdata, e_mwd);
      chk($sformatf("rnd%0d_m_wstrb", n), 32'(m_wstrb), 32'(e_mws));
      chk($sformatf("rnd%0d_rdata", n), i_rdata ^ d_rdata, e_ird ^ e_drd);
      chk($sformatf("rnd%0d_cnts", n), cnt_i_grant + 3 * cnt_d_grant + 7 * cnt_conflict,
          32'(mc_i + 3 * mc_d + 7 * mc_c));

      if (!mb_busy) begin
        if (ip && dp) mc_c++;
        if (ip || dp) begin
          mb_busy = 1; mb_accepted = 0; mb_inst = win_inst; mb_last_inst = win_inst;
          if (win_inst) begin
            mc_i++; mb_write = 0; mb_addr = i_addr; mb_wdata = '0; mb_wstrb = '0;
          end else begin
            mc_d++; mb_write = d_write; mb_addr = d_addr; mb_wdata = d_wdata;
            mb_wstrb = d_write ? d_wstrb : 4'h0;
          end
        end
      end else if (!mb_accepted) begin
        if (m_req_ready) begin
          if (mb_write) mb_busy = 0;
          else mb_accepted = 1;
        end
      end else if (m_rvalid && rr) begin
        mb_busy = 0;
      end
      tick();
    end
    zero_inputs();
    #1;
    chk("rnd_final_cnt_i", cnt_i_grant, 32'(mc_i));
    chk("rnd_final_cnt_d", cnt_d_grant, 32'(mc_d));
    chk("rnd_final_cnt_c", cnt_conflict, 32'(mc_c));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
